led_pio_out: RTL and testbench



---
 rtl/led_pio_out_pkg.sv | 14 +
 rtl/led_pio_out_blink_prescaler.sv | 55 +++++
 rtl/led_pio_out.sv | 98 +++++++++
 tb/tb_led_pio_out.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/led_pio_out_pkg.sv
// Shared register map and STATUS bit layout for the LED output PIO.
package led_pio_out_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int STATUS_PHASE_BIT  = 0;
  localparam int STATUS_ACTIVE_BIT = 1;

endpackage

// File: rtl/led_pio_out_blink_prescaler.sv
// Blink prescaler: a down-counter that reloads from PERIOD and toggles phase on expiry.
// phase_next exposes the post-edge phase so the parent can register out_port in step.
module blink_prescaler #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                phase,
  output logic                phase_next
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt_r;
  logic [PERIOD_W-1:0] cnt_nxt;
  logic                phase_r;

  // Next counter/phase; a load outranks an expiry in the same cycle.
  always_comb begin
    cnt_nxt    = cnt_r;
    phase_next = phase_r;
    if (reset) begin
      cnt_nxt    = '0;
      phase_next = 1'b0;
    end else if (load) begin
      cnt_nxt    = period;
      phase_next = 1'b0;
    end else if (period == '0) begin
      cnt_nxt    = '0;
      phase_next = 1'b0;
    end else if (cnt_r == '0) begin
      cnt_nxt    = period;
      phase_next = ~phase_r;
    end else begin
      cnt_nxt    = cnt_r - ONE;
      phase_next = phase_r;
    end
  end

  // Counter and phase state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt;
      phase_r <= phase_next;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/led_pio_out.sv
// Avalon-MM output PIO: DATA/MASK/PERIOD registers, atomic set/clear,
// hardware blink and a one-cycle registered read mux.
module led_pio_out
  import led_pio_out_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data_r;
  logic [WIDTH-1:0]    mask_r;
  logic [PERIOD_W-1:0] period_r;
  logic [WIDTH-1:0]    data_nxt;
  logic [WIDTH-1:0]    mask_nxt;
  logic [PERIOD_W-1:0] period_nxt;
  logic                period_load;
  logic                phase;
  logic                phase_next;
  logic [31:0]         rd_nxt;
  logic                unused_wd;

  assign unused_wd = ^writedata;

  // Register write decode including the OUTSET/OUTCLEAR read-modify-write.
  always_comb begin
    data_nxt    = data_r;
    mask_nxt    = mask_r;
    period_nxt  = period_r;
    period_load = 1'b0;
    if (chipselect && write) begin
      case (address)
        ADDR_DATA:     data_nxt = writedata[WIDTH-1:0];
        ADDR_MASK:     mask_nxt = writedata[WIDTH-1:0];
        ADDR_PERIOD: begin
          period_nxt  = writedata[PERIOD_W-1:0];
          period_load = 1'b1;
        end
        ADDR_OUTSET:   data_nxt = data_r | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data_nxt = data_r & ~writedata[WIDTH-1:0];
        default:       data_nxt = data_r;
      endcase
    end else begin
      period_load = 1'b0;
    end
  end

  blink_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .load       (period_load),
    .period     (period_nxt),
    .phase      (phase),
    .phase_next (phase_next)
  );

  // Read mux, zero-extended; write-only and reserved offsets read 0.
  always_comb begin
    rd_nxt = 32'd0;
    case (address)
      ADDR_DATA:   rd_nxt[WIDTH-1:0]    = data_r;
      ADDR_MASK:   rd_nxt[WIDTH-1:0]    = mask_r;
      ADDR_PERIOD: rd_nxt[PERIOD_W-1:0] = period_r;
      ADDR_STATUS: begin
        rd_nxt[STATUS_PHASE_BIT]  = phase;
        rd_nxt[STATUS_ACTIVE_BIT] = (period_r != '0);
      end
      default:     rd_nxt = 32'd0;
    endcase
  end

  // Register file, LED drive and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r   <= RESET_VALUE;
      mask_r   <= '0;
      period_r <= '0;
      out_port <= RESET_VALUE;
      readdata <= 32'd0;
    end else begin
      data_r   <= data_nxt;
      mask_r   <= mask_nxt;
      period_r <= period_nxt;
      out_port <= data_nxt ^ (mask_nxt & {WIDTH{phase_next}});
      readdata <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_led_pio_out.sv
// Scoreboard bench for led_pio_out: the driver queues expected values per cycle,
// a negedge monitor pops and compares them against out_port/readdata.
module tb_led_pio_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] act;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  led_pio_out #(.WIDTH(8), .RESET_VALUE(8'hA5), .PERIOD_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due by this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = e.is_rd ? readdata : {24'd0, out_port};
      vectors++;
      if (e.cyc != cyc || act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (due cycle %0d, now %0d)", e.nm, act, e.v, e.cyc, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic cs, input logic wr, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write      = wr;
    address    = a;
    writedata  = d;
  endtask

  // Expectation for the state seen after the next rising edge.
  task automatic expect_val(input bit is_rd, input logic [31:0] v, input string nm);
    exp_t x;
    x.cyc   = cyc + 1;
    x.is_rd = is_rd;
    x.v     = v;
    x.nm    = nm;
    q.push_back(x);
  endtask

  initial begin
    reset = 1'b1;
    bus(1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    tick();
    expect_val(1'b0, 32'hA5, "rst_port");
    expect_val(1'b1, 32'h0, "rst_rd");
    tick();
    reset = 1'b0;

    // Reset values via reads of offsets 0..3.
    expect_val(1'b1, 32'hA5, "rd_data_rst");
    expect_val(1'b0, 32'hA5, "port_idle");
    tick();
    bus(1'b0, 1'b0, 3'd1, 32'd0); expect_val(1'b1, 32'h0, "rd_mask_rst");   tick();
    bus(1'b0, 1'b0, 3'd2, 32'd0); expect_val(1'b1, 32'h0, "rd_period_rst"); tick();
    bus(1'b0, 1'b0, 3'd3, 32'd0); expect_val(1'b1, 32'h0, "rd_status_rst"); tick();

    // DATA write, OUTSET, OUTCLEAR, then read back.
    bus(1'b1, 1'b1, 3'd0, 32'hFFFF_FF0F); expect_val(1'b0, 32'h0F, "port_data");  tick();
    bus(1'b1, 1'b1, 3'd4, 32'h0000_0030); expect_val(1'b0, 32'h3F, "port_set");   tick();
    bus(1'b1, 1'b1, 3'd5, 32'h0000_0003); expect_val(1'b0, 32'h3C, "port_clear"); tick();
    bus(1'b0, 1'b0, 3'd0, 32'd0);         expect_val(1'b1, 32'h3C, "rd_data");    tick();
    bus(1'b0, 1'b0, 3'd4, 32'd0);         expect_val(1'b1, 32'h0,  "rd_outset");  tick();

    // Ignored writes: chipselect low, reserved offset 7.
    bus(1'b0, 1'b1, 3'd0, 32'hFF); expect_val(1'b0, 32'h3C, "port_nocs");  tick();
    bus(1'b1, 1'b1, 3'd7, 32'hFF); expect_val(1'b0, 32'h3C, "port_rsvd");  tick();
    bus(1'b0, 1'b0, 3'd7, 32'd0);  expect_val(1'b1, 32'h0,  "rd_rsvd");    tick();
    bus(1'b0, 1'b0, 3'd0, 32'd0);  expect_val(1'b1, 32'h3C, "rd_data_kept"); tick();

    // Blink: DATA=0, MASK=81, PERIOD=3 -> 4 cycles per half-period.
    bus(1'b1, 1'b1, 3'd0, 32'h00); expect_val(1'b0, 32'h00, "port_data0"); tick();
    bus(1'b1, 1'b1, 3'd1, 32'h81); expect_val(1'b0, 32'h00, "port_mask");  tick();
    bus(1'b1, 1'b1, 3'd2, 32'd3);  expect_val(1'b0, 32'h00, "port_period"); tick();
    bus(1'b0, 1'b0, 3'd3, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      if (k == 1) expect_val(1'b1, 32'h2, "rd_status_active");
      expect_val(1'b0, ((k / 4) % 2 == 1) ? 32'h81 : 32'h00, "port_blink");
      tick();
    end

    // Counter is at 0 now: a PERIOD write must win over the toggle.
    bus(1'b1, 1'b1, 3'd2, 32'd3); expect_val(1'b0, 32'h00, "port_reload_wins"); tick();
    bus(1'b0, 1'b0, 3'd3, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) expect_val(1'b1, 32'h2, "rd_status_pre_toggle");
      if (k == 5) expect_val(1'b1, 32'h3, "rd_status_phase1");
      expect_val(1'b0, (k >= 4) ? 32'h81 : 32'h00, "port_after_reload");
      tick();
    end

    // Reset mid-blink with phase=1: back to RESET_VALUE and no more toggles.
    reset = 1'b1;
    expect_val(1'b0, 32'hA5, "port_midrst");
    expect_val(1'b1, 32'h0,  "rd_midrst");
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) expect_val(1'b1, 32'h0, "rd_status_stopped");
      expect_val(1'b0, 32'hA5, "port_stopped");
      tick();
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
